// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control stage.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store shift/mask, load extract/extend, request legality.
module lsu_align #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_chk_wr,
  input  logic [2:0]        i_chk_func,
  input  logic [1:0]        i_chk_off,
  output logic              o_illegal,
  input  logic [2:0]        i_func,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_st_data,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [DATA_W/8-1:0] o_wr_mask,
  input  logic [DATA_W-1:0] i_rd_word,
  output logic [DATA_W-1:0] o_ld_data
);
  import lsu_pkg::*;

  localparam int unsigned MaskW = DATA_W / 8;

  logic [4:0]        w_shamt;
  logic [3:0]        w_mask_base;
  logic [DATA_W-1:0] w_shifted;

  assign w_shamt   = {i_off, 3'b000};
  assign o_wr_data = i_st_data << w_shamt;
  assign w_shifted = i_rd_word >> w_shamt;
  assign o_wr_mask = MaskW'(w_mask_base) << i_off;

  // Width bits only; the signedness bit is irrelevant to stores.
  always_comb begin
    w_mask_base = MASK_W;
    case (i_func[1:0])
      2'b00:   w_mask_base = MASK_B;
      2'b01:   w_mask_base = MASK_H;
      default: w_mask_base = MASK_W;
    endcase
  end

  always_comb begin
    o_ld_data = w_shifted;
    case (i_func)
      LSU_B:   o_ld_data = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
      LSU_BU:  o_ld_data = {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
      LSU_H:   o_ld_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
      LSU_HU:  o_ld_data = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

  always_comb begin
    o_illegal = 1'b1;
    case (i_chk_func)
      LSU_B:   o_illegal = 1'b0;
      LSU_BU:  o_illegal = i_chk_wr;
      LSU_H:   o_illegal = i_chk_off[0];
      LSU_HU:  o_illegal = i_chk_wr | i_chk_off[0];
      LSU_W:   o_illegal = |i_chk_off;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_ctl.sv
// Load/store control: one request at a time, single-cycle RAM access, held response.
module lsu_ctl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst_n,
  input  logic                i_lsu_req_valid,
  output logic                o_lsu_req_ready,
  input  logic                i_lsu_req_wr,
  input  logic [2:0]          i_lsu_req_func,
  input  logic [ADDR_W-1:0]   i_lsu_req_addr,
  input  logic [DATA_W-1:0]   i_lsu_req_data,
  output logic                o_lsu_resp_valid,
  input  logic                i_lsu_resp_ready,
  output logic [DATA_W-1:0]   o_lsu_resp_data,
  output logic                o_lsu_resp_err,
  output logic                o_ram_rd_en,
  output logic [ADDR_W-1:0]   o_ram_rd_addr,
  input  logic [DATA_W-1:0]   i_ram_rd_data,
  output logic                o_ram_wr_en,
  output logic [ADDR_W-1:0]   o_ram_wr_addr,
  output logic [DATA_W-1:0]   o_ram_wr_data,
  output logic [DATA_W/8-1:0] o_ram_wr_mask
);
  import lsu_pkg::*;

  state_e              r_state, w_state;
  logic                r_wr, w_wr;
  logic [2:0]          r_func, w_func;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_data, w_data;
  logic [DATA_W-1:0]   r_resp_data, w_resp_data;
  logic                r_resp_err, w_resp_err;

  logic                w_illegal;
  logic [DATA_W-1:0]   w_st_data;
  logic [DATA_W/8-1:0] w_st_mask;
  logic [DATA_W-1:0]   w_ld_data;
  logic [ADDR_W-1:0]   w_word_addr;

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_chk_wr   (i_lsu_req_wr),
    .i_chk_func (i_lsu_req_func),
    .i_chk_off  (i_lsu_req_addr[1:0]),
    .o_illegal  (w_illegal),
    .i_func     (r_func),
    .i_off      (r_addr[1:0]),
    .i_st_data  (r_data),
    .o_wr_data  (w_st_data),
    .o_wr_mask  (w_st_mask),
    .i_rd_word  (i_ram_rd_data),
    .o_ld_data  (w_ld_data)
  );

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state     <= IDLE;
      r_wr        <= 1'b0;
      r_func      <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_wr        <= w_wr;
      r_func      <= w_func;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_resp_data <= w_resp_data;
      r_resp_err  <= w_resp_err;
    end
  end

  always_comb begin
    w_state          = r_state;
    w_wr             = r_wr;
    w_func           = r_func;
    w_addr           = r_addr;
    w_data           = r_data;
    w_resp_data      = r_resp_data;
    w_resp_err       = r_resp_err;
    o_lsu_req_ready  = 1'b0;
    o_lsu_resp_valid = 1'b0;
    o_ram_rd_en      = 1'b0;
    o_ram_wr_en      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Ready is masked by the reset pin so it reads 0 while reset is held.
        o_lsu_req_ready = i_sys_rst_n;
        if (i_lsu_req_valid) begin
          w_wr        = i_lsu_req_wr;
          w_func      = i_lsu_req_func;
          w_addr      = i_lsu_req_addr;
          w_data      = i_lsu_req_data;
          w_resp_data = '0;
          w_resp_err  = w_illegal;
          w_state     = w_illegal ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        o_ram_rd_en = ~r_wr;
        o_ram_wr_en = r_wr;
        w_resp_data = r_wr ? '0 : w_ld_data;
        w_state     = RESP;
      end
      RESP: begin
        o_lsu_resp_valid = 1'b1;
        if (i_lsu_resp_ready) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign w_word_addr     = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_ram_rd_addr   = o_ram_rd_en ? w_word_addr : '0;
  assign o_ram_wr_addr   = o_ram_wr_en ? w_word_addr : '0;
  assign o_ram_wr_data   = o_ram_wr_en ? w_st_data : '0;
  assign o_ram_wr_mask   = o_ram_wr_en ? w_st_mask : '0;
  assign o_lsu_resp_data = o_lsu_resp_valid ? r_resp_data : '0;
  assign o_lsu_resp_err  = o_lsu_resp_valid & r_resp_err;

endmodule

// File: tb/tb_lsu_ctl.sv
// Transaction-level model of lsu_ctl with a per-cycle output comparator and a small RAM.
module tb_lsu_ctl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_func;
  logic [31:0] req_addr, req_data;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic        rd_en, wr_en;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [3:0]  wr_mask;

  lsu_ctl #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .i_sys_clk        (clk),
    .i_sys_rst_n      (rst_n),
    .i_lsu_req_valid  (req_valid),
    .o_lsu_req_ready  (req_ready),
    .i_lsu_req_wr     (req_wr),
    .i_lsu_req_func   (req_func),
    .i_lsu_req_addr   (req_addr),
    .i_lsu_req_data   (req_data),
    .o_lsu_resp_valid (resp_valid),
    .i_lsu_resp_ready (resp_ready),
    .o_lsu_resp_data  (resp_data),
    .o_lsu_resp_err   (resp_err),
    .o_ram_rd_en      (rd_en),
    .o_ram_rd_addr    (rd_addr),
    .i_ram_rd_data    (rd_data),
    .o_ram_wr_en      (wr_en),
    .o_ram_wr_addr    (wr_addr),
    .o_ram_wr_data    (wr_data),
    .o_ram_wr_mask    (wr_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM seen by the DUT, and the model's own view of what it must contain.
  logic [31:0] ram  [64];
  logic [31:0] refm [64];
  assign rd_data = ram[rd_addr[7:2]];
  always @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) ram[wr_addr[7:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  bit          exp_zero;
  bit          exp_req_ready, exp_resp_valid, exp_resp_err, exp_rd_en, exp_wr_en;
  logic [31:0] exp_resp_data, exp_rd_addr, exp_wr_addr, exp_wr_data;
  logic [3:0]  exp_wr_mask;

  logic [31:0] last_resp_data, last_wr_data;
  logic        last_resp_err;
  logic [3:0]  last_wr_mask;

  bit          n_wr;
  logic [2:0]  n_f;
  logic [31:0] n_a, n_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, rd_addr, 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_wr_mask"}, 32'(wr_mask), 32'd0);
  endtask

  always @(negedge clk) begin
    if (exp_zero) begin
      chk_zero("rst");
    end else begin
      chk("req_ready", 32'(req_ready), 32'(exp_req_ready));
      chk("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
      chk("rd_en", 32'(rd_en), 32'(exp_rd_en));
      chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
      if (exp_resp_valid) begin
        chk("resp_data", resp_data, exp_resp_data);
        chk("resp_err", 32'(resp_err), 32'(exp_resp_err));
      end
      if (exp_rd_en) chk("rd_addr", rd_addr, exp_rd_addr);
      if (exp_wr_en) begin
        chk("wr_addr", wr_addr, exp_wr_addr);
        chk("wr_data", wr_data, exp_wr_data);
        chk("wr_mask", 32'(wr_mask), 32'(exp_wr_mask));
      end
    end
  end

  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit illegal(input bit wr, input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = size_of(f);
    if (sz == 0) return 1'b1;
    if (wr && f[2]) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] f,
                                            input int off);
    longint v, lim;
    int     sz;
    sz  = size_of(f);
    lim = longint'(1) << (8 * sz);
    v   = (longint'(w) >> (8 * off)) % lim;
    if (!f[2] && sz < 4 && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  task automatic set_idle_exp();
    exp_zero       = 1'b0;
    exp_req_ready  = 1'b1;
    exp_resp_valid = 1'b0;
    exp_resp_err   = 1'b0;
    exp_rd_en      = 1'b0;
    exp_wr_en      = 1'b0;
  endtask

  task automatic gen_next();
    n_wr = 1'($urandom_range(0, 1));
    n_f  = 3'($urandom_range(0, 7));
    n_a  = 32'h100 + 32'($urandom_range(0, 255));
    n_d  = $urandom;
  endtask

  // One transaction, starting #1 after an edge with the DUT idle.
  task automatic do_req(input bit wr, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input bit early);
    bit          ill;
    int          sz, off, idx;
    logic [31:0] exp_d;
    req_valid  = 1'b1;
    req_wr     = wr;
    req_func   = f;
    req_addr   = a;
    req_data   = d;
    resp_ready = 1'($urandom_range(0, 1));
    set_idle_exp();
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_wr     = 1'($urandom_range(0, 1));
    req_func   = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_data   = $urandom;
    ill = illegal(wr, f, a);
    sz  = size_of(f);
    off = int'(a % 4);
    idx = int'(a[7:2]);
    exp_req_ready = 1'b0;
    exp_d = 32'd0;
    if (!ill) begin
      if (wr) begin
        exp_wr_en   = 1'b1;
        exp_wr_addr = a & ~32'd3;
        exp_wr_data = d << (8 * off);
        exp_wr_mask = 4'(((1 << sz) - 1) << off);
        for (int k = 0; k < sz; k++) refm[idx][8*(off+k) +: 8] = d[8*k +: 8];
        last_wr_data = wr_data;
        last_wr_mask = wr_mask;
      end else begin
        exp_rd_en   = 1'b1;
        exp_rd_addr = a & ~32'd3;
        exp_d       = ld_model(refm[idx], f, off);
      end
      @(posedge clk); #1;
      exp_rd_en = 1'b0;
      exp_wr_en = 1'b0;
    end
    exp_resp_valid = 1'b1;
    exp_resp_data  = exp_d;
    exp_resp_err   = ill;
    resp_ready     = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (early) begin
        req_valid = 1'b1;
        req_wr    = n_wr;
        req_func  = n_f;
        req_addr  = n_a;
        req_data  = n_d;
      end
      @(posedge clk); #1;
    end
    last_resp_data = resp_data;
    last_resp_err  = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    set_idle_exp();
  endtask

  bit          c_wr;
  logic [2:0]  c_f;
  logic [31:0] c_a, c_d, old_word;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_func   = 3'b0;
    req_addr   = 32'd0;
    req_data   = 32'd0;
    resp_ready = 1'b0;
    exp_zero   = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ram[i]  = $urandom;
      refm[i] = ram[i];
    end
    ram[0]  = 32'h80FF1234;
    refm[0] = 32'h80FF1234;

    chk("model_lb", ld_model(32'h80FF1234, 3'b000, 3), 32'hFFFFFF80);
    chk("model_lhu", ld_model(32'h80FF1234, 3'b101, 2), 32'h000080FF);
    chk("model_ill_sw", 32'(illegal(1'b1, 3'b010, 32'h102)), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_idle_exp();
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resp_ready = 1'b0;

    do_req(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
    chk("lw_data", last_resp_data, 32'h80FF1234);
    chk("lw_err", 32'(last_resp_err), 32'd0);
    do_req(1'b0, 3'b000, 32'h103, 32'h0, 1, 1'b0);
    chk("lb_data", last_resp_data, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b0);
    chk("lbu_data", last_resp_data, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 0, 1'b0);
    chk("lh_data", last_resp_data, 32'hFFFF80FF);
    do_req(1'b0, 3'b101, 32'h102, 32'h0, 0, 1'b0);
    chk("lhu_data", last_resp_data, 32'h000080FF);

    do_req(1'b1, 3'b000, 32'h101, 32'h000000AB, 0, 1'b0);
    chk("sb_wr_data", last_wr_data, 32'h0000AB00);
    chk("sb_wr_mask", 32'(last_wr_mask), 32'h2);
    chk("sb_resp", last_resp_data, 32'd0);
    do_req(1'b1, 3'b001, 32'h102, 32'h00001234, 0, 1'b0);
    chk("sh_wr_data", last_wr_data, 32'h12340000);
    chk("sh_wr_mask", 32'(last_wr_mask), 32'hC);
    do_req(1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 0, 1'b0);
    chk("sw_mis_err", 32'(last_resp_err), 32'd1);
    chk("sw_mis_data", last_resp_data, 32'd0);
    do_req(1'b0, 3'b011, 32'h104, 32'h0, 0, 1'b0);
    chk("bad_func_err", 32'(last_resp_err), 32'd1);
    chk("ram_after_stores", ram[0], 32'h1234AB34);

    // Backpressure with the next request waiting at the port.
    n_wr = 1'b0;
    n_f  = 3'b010;
    n_a  = 32'h104;
    n_d  = 32'd0;
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 5, 1'b1);
    chk("bp_data", last_resp_data, 32'h1234AB34);
    do_req(n_wr, n_f, n_a, n_d, 0, 1'b0);

    // Reset lands while a word store sits in ACCESS.
    old_word  = ram[16];
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_func  = 3'b010;
    req_addr  = 32'h140;
    req_data  = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_acc_wr_en", 32'(wr_en), 32'd1);
    #1;
    rst_n    = 1'b0;
    exp_zero = 1'b1;
    #1;
    chk_zero("rst_now");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_idle_exp();
    chk("rst_no_write", ram[16], old_word);
    do_req(1'b0, 3'b010, 32'h140, 32'h0, 0, 1'b0);
    chk("rst_word_kept", last_resp_data, old_word);

    gen_next();
    for (int i = 0; i < 300; i++) begin
      c_wr = n_wr;
      c_f  = n_f;
      c_a  = n_a;
      c_d  = n_d;
      gen_next();
      do_req(c_wr, c_f, c_a, c_d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 64; i++) chk("final_ram", ram[i], refm[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
